fb_write_arbiter: RTL and testbench

//  Owns the single write port of the 1-bit 640x480 frame-buffer RAM (bigram wraddress/data/wren).

---
 rtl/fb_write_arbiter_if.sv | 27 ++
 rtl/fb_write_arbiter.sv | 117 +++++++++++
 tb/tb_fb_write_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fb_write_arbiter_if.sv
// Frame-buffer write-port bundle: two trail writers, clear control, and the RAM write bus.
interface fb_write_arbiter_if #(parameter int ADDR_W = 19);
  logic              clear_start;
  logic              clear_busy;
  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic              p0_data;
  logic              p0_ack;
  logic              p1_req;
  logic [ADDR_W-1:0] p1_addr;
  logic              p1_data;
  logic              p1_ack;
  logic [ADDR_W-1:0] ram_wraddress;
  logic              ram_data;
  logic              ram_wren;
  logic              oob;

  modport master (
    output clear_start, p0_req, p0_addr, p0_data, p1_req, p1_addr, p1_data,
    input  clear_busy, p0_ack, p1_ack, ram_wraddress, ram_data, ram_wren, oob
  );

  modport slave (
    input  clear_start, p0_req, p0_addr, p0_data, p1_req, p1_addr, p1_data,
    output clear_busy, p0_ack, p1_ack, ram_wraddress, ram_data, ram_wren, oob
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Owns the frame-buffer write port: round-robin between two trail writers plus a
// full-frame clear engine that locks out both writers while it sweeps every address.
module fb_write_arbiter #(
  parameter int ADDR_W = 19,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480
) (
  input  logic             clock,
  input  logic             reset_n,
  fb_write_arbiter_if.slave bus
);
  localparam int N_PIX = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N_PIX - 1);
  // one extra bit so N_PIX == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0]   NPIX_W = (ADDR_W+1)'(N_PIX);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              oob_q, oob_d;

  logic              ack0, ack1;
  logic [ADDR_W-1:0] g_addr;
  logic              g_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.clear_start)     state_d = CLEAR;
      CLEAR:   if (clr_cnt_q == LAST_A) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grants only in IDLE, and a clear request pre-empts both writers that cycle.
  always_comb begin
    ack0 = 1'b0;
    ack1 = 1'b0;
    if (reset_n && state_q == IDLE && !bus.clear_start) begin
      ack0 = bus.p0_req & (~bus.p1_req | ~rr_q);
      ack1 = bus.p1_req & (~bus.p0_req |  rr_q);
    end
  end

  assign bus.p0_ack = ack0;
  assign bus.p1_ack = ack1;

  assign g_addr = ack1 ? bus.p1_addr : bus.p0_addr;
  assign g_data = ack1 ? bus.p1_data : bus.p0_data;

  always_comb begin
    rr_d      = rr_q;
    clr_cnt_d = clr_cnt_q;
    wren_d    = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    oob_d     = 1'b0;
    if (state_q == CLEAR) begin
      wren_d    = 1'b1;
      waddr_d   = clr_cnt_q;
      wdata_d   = 1'b0;
      clr_cnt_d = clr_cnt_q + 1'b1;
    end else if (bus.clear_start) begin
      clr_cnt_d = '0;
    end else if (ack0 | ack1) begin
      // winner loses priority only when the other side was also asking
      if (bus.p0_req & bus.p1_req) rr_d = ack0;
      if ({1'b0, g_addr} >= NPIX_W) begin
        oob_d = 1'b1;
      end else begin
        wren_d  = 1'b1;
        waddr_d = g_addr;
        wdata_d = g_data;
      end
    end
  end

  // Covers the cycle after acceptance through the final clear write.
  assign busy_d = (state_d == CLEAR) | (state_q == CLEAR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q      <= 1'b0;
      clr_cnt_q <= '0;
      wren_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= 1'b0;
      busy_q    <= 1'b0;
      oob_q     <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      clr_cnt_q <= clr_cnt_d;
      wren_q    <= wren_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      oob_q     <= oob_d;
    end
  end

  assign bus.ram_wren      = wren_q;
  assign bus.ram_wraddress = waddr_q;
  assign bus.ram_data      = wdata_q;
  assign bus.clear_busy    = busy_q;
  assign bus.oob           = oob_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized bench for fb_write_arbiter on a reduced 16x8 frame, checked each cycle
// against a cycle-level model of the arbitration and clear-sweep rules.
module tb_fb_write_arbiter;
  localparam int ADDR_W = 19;
  localparam int H_RES  = 16;
  localparam int V_RES  = 8;
  localparam int N      = H_RES * V_RES;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fb_write_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  fb_write_arbiter #(.ADDR_W(ADDR_W), .H_RES(H_RES), .V_RES(V_RES)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // requester side: a request stays up, unchanged, until it is acked
  bit              pend  [2];
  logic [ADDR_W-1:0] paddr [2];
  bit              pdata [2];
  bit              auto_en = 0;
  bit              fixed_en = 0;
  int              req_pct = 50;
  logic [ADDR_W-1:0] fa [2];

  // reference model: priority holder, remaining sweep cycles, expected registered outputs
  bit              m_prio;
  int              m_clear_left;
  bit              e_wren, e_data, e_busy, e_oob;
  logic [ADDR_W-1:0] e_addr;
  int              acks_seen [2];
  int              clr_writes;

  function automatic logic [ADDR_W-1:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r == 0)      return ADDR_W'(N);
    else if (r == 1) return ADDR_W'(N - 1);
    else if (r == 2) return ADDR_W'($urandom);
    else             return ADDR_W'($urandom_range(0, N - 1));
  endfunction

  task automatic set_req(input int p, input logic [ADDR_W-1:0] a, input bit d);
    pend[p] = 1; paddr[p] = a; pdata[p] = d;
  endtask

  task automatic model_reset();
    m_prio = 0; m_clear_left = 0;
    e_wren = 0; e_data = 0; e_busy = 0; e_oob = 0; e_addr = '0;
  endtask

  task automatic drive(input bit clr);
    bus.clear_start = clr;
    bus.p0_req  = pend[0]; bus.p0_addr = paddr[0]; bus.p0_data = pdata[0];
    bus.p1_req  = pend[1]; bus.p1_addr = paddr[1]; bus.p1_data = pdata[1];
  endtask

  task automatic cycle(input bit clr);
    bit x0, x1, won;
    int w;
    @(negedge clock);
    reset_n = 1'b1;
    chk("ram_wren",      bus.ram_wren,      e_wren);
    chk("ram_wraddress", bus.ram_wraddress, e_addr);
    chk("ram_data",      bus.ram_data,      e_data);
    chk("clear_busy",    bus.clear_busy,    e_busy);
    chk("oob",           bus.oob,           e_oob);
    if (bus.ram_wren && bus.clear_busy) clr_writes++;
    if (auto_en)
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 99) < req_pct)
          set_req(p, fixed_en ? fa[p] : rand_addr(), bit'($urandom_range(0, 1)));
    drive(clr);
    #1;
    x0 = 0; x1 = 0; won = 0; w = 0;
    e_oob = 0;
    if (m_clear_left > 0) begin
      e_wren = 1; e_addr = ADDR_W'(N - m_clear_left); e_data = 0; e_busy = 1;
      m_clear_left--;
    end else if (clr) begin
      e_wren = 0; e_busy = 1; m_clear_left = N;
    end else begin
      e_wren = 0; e_busy = 0;
      if (pend[0] && pend[1]) begin
        w = m_prio; won = 1; m_prio = ~m_prio;
        if (w == 1) m_prio = 0; else m_prio = 1;
      end else if (pend[0] || pend[1]) begin
        w = pend[1] ? 1 : 0; won = 1;
      end
      if (won) begin
        if (w == 0) x0 = 1; else x1 = 1;
        if (int'(paddr[w]) >= N) e_oob = 1;
        else begin e_wren = 1; e_addr = paddr[w]; e_data = pdata[w]; end
      end
    end
    chk("p0_ack", bus.p0_ack, x0);
    chk("p1_ack", bus.p1_ack, x1);
    if (x0) begin pend[0] = 0; acks_seen[0]++; end
    if (x1) begin pend[1] = 0; acks_seen[1]++; end
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    reset_n = 1'b0;
    drive(1'b0);
    #1;
    chk("rst_wren", bus.ram_wren,   1'b0);
    chk("rst_busy", bus.clear_busy, 1'b0);
    chk("rst_oob",  bus.oob,        1'b0);
    chk("rst_addr", bus.ram_wraddress, '0);
    chk("rst_ack0", bus.p0_ack, 1'b0);
    chk("rst_ack1", bus.p1_ack, 1'b0);
    model_reset();
    repeat (2) @(negedge clock);
  endtask

  initial begin
    pend[0] = 0; pend[1] = 0; paddr[0] = '0; paddr[1] = '0; pdata[0] = 0; pdata[1] = 0;
    acks_seen[0] = 0; acks_seen[1] = 0; clr_writes = 0;
    model_reset();
    set_req(0, ADDR_W'(5), 1);
    drive(1'b0);
    #1;
    chk("init_wren", bus.ram_wren, 1'b0);
    chk("init_busy", bus.clear_busy, 1'b0);
    chk("init_ack0", bus.p0_ack, 1'b0);
    repeat (2) @(negedge clock);

    // single write, latency one
    cycle(0);
    cycle(0);

    // both held high on fixed addresses: strict alternation
    auto_en = 1; fixed_en = 1; req_pct = 100; fa[0] = ADDR_W'(10); fa[1] = ADDR_W'(20);
    repeat (10) cycle(0);
    auto_en = 0; fixed_en = 0;
    repeat (3) cycle(0);

    // clear with a stalled writer, then writer served
    set_req(0, ADDR_W'(7), 1);
    clr_writes = 0;
    cycle(1);
    repeat (N + 4) cycle(0);
    chk("clear_count", clr_writes, N);
    chk("p0_after_clear", pend[0], 1'b0);

    // out-of-bounds requests: exactly N and far out
    set_req(1, ADDR_W'(N), 0);
    repeat (3) cycle(0);
    set_req(1, {ADDR_W{1'b1}}, 1);
    repeat (3) cycle(0);

    // reset in the middle of a clear
    set_req(0, ADDR_W'(33), 1);
    cycle(1);
    repeat (N / 3) cycle(0);
    reset_pulse();
    acks_seen[0] = 0;
    repeat (N + 4) cycle(0);
    chk("p0_after_reset", acks_seen[0], 1);

    // extra clear_start pulses while sweeping
    clr_writes = 0;
    cycle(1);
    repeat (10) cycle(0);
    cycle(1);
    repeat (N / 2) cycle(0);
    cycle(1);
    repeat (N) cycle(0);
    chk("clear_count_restart", clr_writes, N);

    // random traffic with occasional clears
    auto_en = 1; req_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      req_pct = (i % 500 < 250) ? 60 : 95;
      cycle(bit'($urandom_range(0, 199) == 0));
    end
    auto_en = 0;
    repeat (N + 4) cycle(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
